// File: rtl/pwm_width_scheduler_pkg.sv
// Shared types and constants for the PWM width scheduler.
// Optional sweep logic is compiled in with the PWM_SWEEP_EN macro.
package pwm_width_scheduler_pkg;

  localparam int N_DEFAULT   = 14;
  localparam int M_DEFAULT   = 12;
  localparam int SWEEP_DIV_W = 8;

  typedef enum logic [1:0] {
    STATIC     = 2'd0,
    PENDING    = 2'd1,
    SWEEP_UP   = 2'd2,
    SWEEP_DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_width_scheduler_wrap_detect.sv
// Phase-period boundary detector: registers the phase MSB and pulses wrap
// for one cycle after the MSB falls from 1 to 0.
module pwm_wrap_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic phase_msb,
  output logic wrap
);

  logic msb_q;

  // msb_q resets to 0, so a wrap needs two sampled edges after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_q <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      msb_q <= phase_msb;
      wrap  <= msb_q & ~phase_msb;
    end
  end

endmodule

// File: rtl/pwm_width_scheduler.sv
// PWM width scheduler: applies written or swept widths only on phase wraps.
// Sweep (triangle) logic is present only when PWM_SWEEP_EN is defined.
module pwm_width_scheduler
  import pwm_width_scheduler_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int M = M_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           phase,
  input  logic                   wr_valid,
  input  logic [M-1:0]           wr_width,
  output logic                   wr_ready,
  input  logic                   sweep_on,
  input  logic [M-1:0]           sweep_min,
  input  logic [M-1:0]           sweep_max,
  input  logic [M-1:0]           sweep_step,
  input  logic [SWEEP_DIV_W-1:0] sweep_div,
  output logic [M-1:0]           mod,
  output logic                   wrap,
  output state_t                 state_dbg
);

  state_t       state_q, state_d;
  logic [M-1:0] mod_q, mod_d;
  logic [M-1:0] pend_q, pend_d;
  logic         wr_xfer;
  logic         unused_phase_lsbs;

  assign unused_phase_lsbs = ^phase[N-2:0];

  pwm_wrap_detect u_wrap_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_msb (phase[N-1]),
    .wrap      (wrap)
  );

  // Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready depends only on state, never on wr_valid.
  assign wr_ready = (state_q != PENDING);
  assign wr_xfer  = wr_valid & wr_ready;

`ifdef PWM_SWEEP_EN
  logic [SWEEP_DIV_W-1:0] div_q, div_d, div_lim;
  logic [SWEEP_DIV_W:0]   div_inc;
  logic [M-1:0]           clamp_mod, step_mod;
  logic [M:0]             up_sum, lo_sum;
  state_t                 step_state;

  assign div_lim = (sweep_div == '0) ? {{(SWEEP_DIV_W-1){1'b0}}, 1'b1} : sweep_div;
  assign div_inc = {1'b0, div_q} + {{SWEEP_DIV_W{1'b0}}, 1'b1};

  // Sums are M+1 bits wide so saturation is decided before any wrap-around.
  always_comb begin
    step_mod   = mod_q;
    step_state = state_q;
    clamp_mod  = mod_q;
    if (mod_q < sweep_min) clamp_mod = sweep_min;
    else if (mod_q > sweep_max) clamp_mod = sweep_max;
    up_sum = {1'b0, clamp_mod} + {1'b0, sweep_step};
    lo_sum = {1'b0, sweep_min} + {1'b0, sweep_step};
    if (sweep_step == '0) begin
      step_mod = mod_q;
    end else if (sweep_min >= sweep_max) begin
      step_mod = sweep_min;
    end else if (state_q == SWEEP_UP) begin
      if (up_sum >= {1'b0, sweep_max}) begin
        step_mod   = sweep_max;
        step_state = SWEEP_DOWN;
      end else begin
        step_mod = up_sum[M-1:0];
      end
    end else begin
      if ({1'b0, clamp_mod} <= lo_sum) begin
        step_mod   = sweep_min;
        step_state = SWEEP_UP;
      end else begin
        step_mod = clamp_mod - sweep_step;
      end
    end
  end
`else
  logic unused_sweep;
  assign unused_sweep = ^{sweep_on, sweep_min, sweep_max, sweep_step, sweep_div};
`endif

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    pend_d  = pend_q;
`ifdef PWM_SWEEP_EN
    div_d   = div_q;
`endif
    case (state_q)
      STATIC: begin
        if (wr_xfer) begin
          pend_d  = wr_width;
          state_d = PENDING;
`ifdef PWM_SWEEP_EN
        end else if (sweep_on) begin
          state_d = SWEEP_UP;
          div_d   = '0;
`endif
        end
      end
      PENDING: begin
        if (wrap) begin
          mod_d   = pend_q;
          state_d = STATIC;
`ifdef PWM_SWEEP_EN
          div_d   = '0;
          if (sweep_on) state_d = SWEEP_UP;
`endif
        end
      end
`ifdef PWM_SWEEP_EN
      SWEEP_UP, SWEEP_DOWN: begin
        if (wr_xfer) begin
          pend_d  = wr_width;
          state_d = PENDING;
        end else if (wrap) begin
          if (!sweep_on) begin
            state_d = STATIC;
          end else if (div_inc >= {1'b0, div_lim}) begin
            div_d   = '0;
            mod_d   = step_mod;
            state_d = step_state;
          end else begin
            div_d = div_inc[SWEEP_DIV_W-1:0];
          end
        end
      end
`endif
      default: state_d = STATIC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATIC;
      mod_q   <= '0;
      pend_q  <= '0;
`ifdef PWM_SWEEP_EN
      div_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      pend_q  <= pend_d;
`ifdef PWM_SWEEP_EN
      div_q   <= div_d;
`endif
    end
  end

  assign mod       = mod_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pwm_width_scheduler.sv
// Self-checking bench for pwm_width_scheduler; sweep scenarios run when
// PWM_SWEEP_EN is defined, the sweep-ignored scenario otherwise.
module tb_pwm_width_scheduler;
  import pwm_width_scheduler_pkg::*;

  localparam int N = 14;
  localparam int M = 12;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           phase;
  logic [N-1:0]           phase_inc;
  logic                   wr_valid;
  logic [M-1:0]           wr_width;
  logic                   wr_ready;
  logic                   sweep_on;
  logic [M-1:0]           sweep_min, sweep_max, sweep_step;
  logic [SWEEP_DIV_W-1:0] sweep_div;
  logic [M-1:0]           mod;
  logic                   wrap;
  state_t                 state_dbg;

  logic [M-1:0] exp_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;

  pwm_width_scheduler #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase      (phase),
    .wr_valid   (wr_valid),
    .wr_width   (wr_width),
    .wr_ready   (wr_ready),
    .sweep_on   (sweep_on),
    .sweep_min  (sweep_min),
    .sweep_max  (sweep_max),
    .sweep_step (sweep_step),
    .sweep_div  (sweep_div),
    .mod        (mod),
    .wrap       (wrap),
    .state_dbg  (state_dbg)
  );

  // clock / phase generation
  always #5 clk = ~clk;

  initial begin
    phase     = '0;
    phase_inc = '0;
    forever begin
      @(negedge clk);
      phase = phase + phase_inc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every mod change must happen on a wrap edge and match the queue
  logic [M-1:0] prev_mod  = '0;
  logic         wrap_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_mod = '0;
      end else if (mod !== prev_mod) begin
        check_eq("mod_at_wrap", wrap_prev, 1);
        if (exp_q.size() == 0) check_eq("mod_unexpected", mod, prev_mod);
        else check_eq("mod_seq", mod, exp_q.pop_front());
        prev_mod = mod;
      end
      wrap_prev = wrap;
    end
  end

  // driver tasks
  task automatic wait_wrap_high(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (wrap !== 1'b1 && n < 20000);
    if (wrap !== 1'b1) check_eq({tag, "_timeout"}, wrap, 1);
  endtask

  task automatic wait_wrap(input string tag);
    wait_wrap_high(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [M-1:0] w);
    @(negedge clk);
    check_eq("wr_ready_idle", wr_ready, 1);
    wr_valid = 1'b1;
    wr_width = w;
    exp_q.push_back(w);
    @(negedge clk);
    wr_valid = 1'b0;
    check_eq("wr_ready_busy", wr_ready, 0);
  endtask

  initial begin
    logic [M-1:0] seq3[4];
    logic [M-1:0] seq4[4];
    logic [M-1:0] cur;
    seq3 = '{12'h120, 12'h140, 12'h120, 12'h100};
    seq4 = '{12'h140, 12'h110, 12'h100, 12'h130};

    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_width   = '0;
    sweep_on   = 1'b0;
    sweep_min  = 12'h100;
    sweep_max  = 12'h140;
    sweep_step = 12'h020;
    sweep_div  = 8'd2;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mod", mod, 0);
    check_eq("rst_ready", wr_ready, 1);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_state", state_dbg, STATIC);

    @(negedge clk);
    rst_n     = 1'b1;
    phase_inc = 14'd1;
    @(posedge clk);
    #1;
    check_eq("wrap_first_edge", wrap, 0);

    // V1: write held pending until the first wrap of a slow ramp
    do_write(12'h400);
    wait_wrap_high("v1");
    check_eq("v1_ready_low", wr_ready, 0);
    check_eq("v1_mod_before", mod, 0);
    @(posedge clk);
    #1;
    check_eq("v1_mod", mod, 12'h400);
    check_eq("v1_ready_high", wr_ready, 1);

    @(negedge clk);
    phase_inc = 14'd256;

    // V2: write in the wrap cycle lands one period later
    wait_wrap_high("v2_sync");
    do_write(12'h100);
    check_eq("v2_hold", mod, 12'h400);
    wait_wrap("v2");
    check_eq("v2_mod", mod, 12'h100);

`ifdef PWM_SWEEP_EN
    // V3: triangle sweep, one step every two wraps
    @(negedge clk);
    sweep_on = 1'b1;
    cur = 12'h100;
    foreach (seq3[i]) exp_q.push_back(seq3[i]);
    for (int i = 0; i < 4; i++) begin
      wait_wrap("v3a");
      check_eq("v3_hold", mod, cur);
      wait_wrap("v3b");
      check_eq("v3_step", mod, seq3[i]);
      cur = seq3[i];
    end

    // V4: saturation at sweep_max, divider 0 acting as 1
    @(negedge clk);
    sweep_step = 12'h030;
    sweep_div  = 8'd0;
    do_write(12'h130);
    wait_wrap("v4_load");
    check_eq("v4_load", mod, 12'h130);
    check_eq("v4_load_state", state_dbg, SWEEP_UP);
    foreach (seq4[i]) exp_q.push_back(seq4[i]);
    for (int i = 0; i < 4; i++) begin
      wait_wrap("v4");
      check_eq("v4_step", mod, seq4[i]);
      if (i == 0) check_eq("v4_dir_down", state_dbg, SWEEP_DOWN);
      if (i == 2) check_eq("v4_dir_up", state_dbg, SWEEP_UP);
    end

    @(negedge clk);
    sweep_on = 1'b0;
    wait_wrap("off");
    check_eq("sweep_off_hold", mod, 12'h130);
    check_eq("sweep_off_state", state_dbg, STATIC);
    wait_wrap("off2");
    check_eq("sweep_off_hold2", mod, 12'h130);
`else
    // V6: sweep inputs ignored; only writes move mod
    @(negedge clk);
    sweep_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_wrap("v6");
      check_eq("v6_hold", mod, 12'h100);
      check_eq("v6_ready", wr_ready, 1);
    end
    do_write(12'h155);
    wait_wrap("v6_load");
    check_eq("v6_mod", mod, 12'h155);
    wait_wrap("v6_after");
    check_eq("v6_hold2", mod, 12'h155);
`endif

    // V5: asynchronous reset while a write is pending
    do_write(12'h2AA);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("v5_mod", mod, 0);
    check_eq("v5_ready", wr_ready, 1);
    check_eq("v5_wrap", wrap, 0);
    check_eq("v5_state", state_dbg, STATIC);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_wrap("v5a");
    check_eq("v5_discard", mod, 0);
    wait_wrap("v5b");
    check_eq("v5_discard2", mod, 0);
    check_eq("v5_ready_after", wr_ready, 1);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pwm_width_scheduler.md
PWM_WIDTH_SCHEDULER -- requirements
Module: pwm_width_scheduler

Interface
REQ-001 Parameter N, default 14: phase accumulator width.
REQ-002 Parameter M, default 12: pulse-width (mod) width; M <= N.
REQ-003 clk  input  1  single system clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 phase  input  N  DDS phase accumulator value.
REQ-006 wr_valid  input  1  new static width offered.
REQ-007 wr_width  input  M  requested width.
REQ-008 wr_ready  output  1  scheduler can accept a write.
REQ-009 sweep_on  input  1  enables automatic triangle sweep of width.
REQ-010 sweep_min / sweep_max  input  M each  sweep bounds, inclusive.
REQ-011 sweep_step  input  M  width increment per sweep step.
REQ-012 sweep_div  input  8  phase periods per sweep step, 0 treated as 1.
REQ-013 mod  output  M  width driven to the PWM comparator.
REQ-014 wrap  output  1  one-cycle pulse on each phase period boundary.

Function
REQ-015 Boundary detect: wrap=1 in the cycle after the registered phase[N-1] is 1 and the current phase[N-1] is 0; otherwise wrap=0.
REQ-016 mod changes only on a clock edge where wrap=1, so no pulse is truncated mid-period.
REQ-017 FSM states are STATIC, PENDING, SWEEP_UP and SWEEP_DOWN; the reset state is STATIC.
REQ-018 Handshake: a write transfers when wr_valid and wr_ready are both 1; wr_ready=1 in every state except PENDING.
REQ-019 On a write transfer, wr_width is captured into a pending register and the FSM enters PENDING.
REQ-020 In PENDING on a wrap edge, mod loads the pending value; the next state is SWEEP_UP if sweep_on=1, else STATIC.
REQ-021 If a wrap and a write transfer occur in the same cycle, the write is captured, and mod takes it at the following wrap (1-period latency minimum).
REQ-022 In STATIC with sweep_on=1, the FSM enters SWEEP_UP; the divider counter is cleared.
REQ-023 In a sweep state, each wrap increments the divider; when it reaches max(sweep_div,1), the divider clears and a step is applied.
REQ-024 Step in SWEEP_UP: mod = min(mod+sweep_step, sweep_max), computed in M+1 bits with no wrap-around; on reaching sweep_max the FSM moves to SWEEP_DOWN.
REQ-025 Step in SWEEP_DOWN: mod = max(mod-sweep_step, sweep_min), with no underflow; on reaching sweep_min the FSM moves to SWEEP_UP.
REQ-026 If mod lies outside [sweep_min, sweep_max] at a step, mod is clamped into range first.
REQ-027 If sweep_min >= sweep_max or sweep_step = 0, steps hold mod at sweep_min, or at mod when the step is 0.
REQ-028 A write during a sweep enters PENDING; the sweep resumes in SWEEP_UP from the loaded value.
REQ-029 If sweep_on=0 in a sweep state, the FSM enters STATIC at the next wrap and mod holds.

Reset
REQ-030 While rst_n=0: mod=0, wrap=0, wr_ready=1, state=STATIC, divider=0, pending=0 and the registered phase MSB=0.
REQ-031 Reset asserted mid-operation discards any pending write immediately, without waiting for a wrap.
REQ-032 After reset release, the first wrap is never reported before two rising edges have sampled phase.

Configuration
REQ-033 The macro PWM_SWEEP_EN compiles in the sweep logic.
REQ-034 When PWM_SWEEP_EN is undefined, the SWEEP_UP/SWEEP_DOWN states, the divider and the step arithmetic are removed; the sweep_* inputs remain as ports but are ignored, and PENDING always returns to STATIC.

Structure
REQ-035 The shared package holds the FSM state enum, the defaults for N and M, and the sweep_div width constant (8).
REQ-036 One sub-module, pwm_wrap_detect, contains the MSB register and the wrap pulse logic.

Verification
REQ-037 Bench V1: reset, then write 0x400 with phase ramping by 1 -> mod=0x400 exactly at the first wrap; wr_ready=0 until then.
REQ-038 Bench V2: write 0x100 in the same cycle as a wrap -> mod is unchanged at that wrap and becomes 0x100 at the next wrap.
REQ-039 Bench V3: sweep with min=0x100, max=0x140, step=0x20, div=2 -> mod follows 0x100, 0x120, 0x140, 0x120, 0x100, changing every 2 wraps.
REQ-040 Bench V4: sweep with step=0x30, max=0x140, mod=0x130 -> mod saturates at 0x140 and the direction reverses; no wrap-around.
REQ-041 Bench V5: assert rst_n low mid-PENDING -> mod=0 and wr_ready=1 asynchronously, and the pending value is never applied.
REQ-042 Bench V6: build without PWM_SWEEP_EN and sweep_on=1 -> mod changes only on writes.
